// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: shared widths, opmode fields and post-adder arithmetic
package dsp48a1_pkg;
  localparam int DW = 48;
  localparam int MW = 36;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;
  localparam int OPM_CIN = 5;
  localparam int OPM_SUB = 7;
  // Bit DW of the result is the carry on add and the borrow on subtract.
  function automatic logic [DW:0] post_add(input logic [DW-1:0] z, input logic [DW-1:0] x,
                                           input logic cin, input logic sub);
    logic [DW:0] xc;
    xc = {1'b0, x} + {{DW{1'b0}}, cin};
    return sub ? {1'b0, z} - xc : {1'b0, z} + xc;
  endfunction
endpackage

// File: rtl/sync_reg_mux.sv
// sync_reg_mux: optional pipeline register with clock enable and sync reset
module sync_reg_mux #(
  parameter int WIDTH = 1,
  parameter bit REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d_q;
  always_ff @(posedge clk)
    if (rst) d_q <= '0;
    else if (ce) d_q <= d;
  assign q = REG ? d_q : d;
endmodule

// File: rtl/dsp_post_adder_acc.sv
// dsp_post_adder_acc: DSP48A1-style post-adder/accumulator with optional pipeline stages
module dsp_post_adder_acc
  import dsp48a1_pkg::*;
#(
  parameter int PREG = 1,
  parameter int CARRYOUTREG = 1,
  parameter int OPMODEREG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_opmode,
  input  logic          ce_p,
  input  logic [7:0]    opmode,
  input  logic [MW-1:0] m,
  input  logic [DW-1:0] dab,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] pcin,
  input  logic          carryin,
  output logic [DW-1:0] p,
  output logic [DW-1:0] pcout,
  output logic          carryout,
  output logic          carryoutf
);
  logic [7:0] opm;
  logic [DW-1:0] fb, x, z;
  logic [DW:0] res;
  logic cin;
  logic unused_opm;
  sync_reg_mux #(.WIDTH(8), .REG(OPMODEREG != 0)) u_opm (
    .clk(clk), .rst(rst), .ce(ce_opmode), .d(opmode), .q(opm)
  );
  assign unused_opm = ^{opm[6], opm[4]};
  // Without a P register the feedback path would be a combinational loop.
  always_comb begin
    fb = (PREG != 0) ? p : '0;
    x = opm[1:0] == X_ZERO ? '0 : opm[1:0] == X_M ? {{(DW-MW){1'b0}}, m} : opm[1:0] == X_P ? fb : dab;
    z = opm[3:2] == Z_ZERO ? '0 : opm[3:2] == Z_PCIN ? pcin : opm[3:2] == Z_P ? fb : c;
    cin = carryin & opm[OPM_CIN];
    res = post_add(z, x, cin, opm[OPM_SUB]);
  end
  sync_reg_mux #(.WIDTH(DW), .REG(PREG != 0)) u_p (
    .clk(clk), .rst(rst), .ce(ce_p), .d(res[DW-1:0]), .q(p)
  );
  sync_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG != 0)) u_co (
    .clk(clk), .rst(rst), .ce(ce_p), .d(res[DW]), .q(carryout)
  );
  assign pcout = p;
  assign carryoutf = carryout;
endmodule

// File: doc/dsp_post_adder_acc.md
DSP_POST_ADDER_ACC -- requirements
Module: dsp_post_adder_acc

Interface
REQ-001 SHALL have parameter PREG, default 1, meaning 1 = P output registered and 0 = P output combinational.
REQ-002 SHALL have parameter CARRYOUTREG, default 1, meaning 1 = carry output registered and 0 = carry output combinational.
REQ-003 SHALL have parameter OPMODEREG, default 1, meaning 1 = opmode registered before use and 0 = opmode used directly.
REQ-004 SHALL have port clk, input, 1 bit, single rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port ce_opmode, input, 1 bit, clock enable of the opmode register.
REQ-007 SHALL have port ce_p, input, 1 bit, clock enable of the P and carryout registers.
REQ-008 SHALL have port opmode, input, 8 bits: [1:0] X select, [3:2] Z select, [5] carry-in enable, [7] subtract.
REQ-009 SHALL have port m, input, 36 bits, multiplier product from the upstream M stage.
REQ-010 SHALL have port dab, input, 48 bits, D:A:B concatenation.
REQ-011 SHALL have ports c and pcin, inputs, 48 bits each, C operand and cascade input.
REQ-012 SHALL have port carryin, input, 1 bit, carry into the post-adder.
REQ-013 SHALL have ports p and pcout, outputs, 48 bits each; pcout SHALL always equal p.
REQ-014 SHALL have ports carryout and carryoutf, outputs, 1 bit each; carryoutf SHALL always equal carryout.

Function
REQ-015 SHALL select X from opmode[1:0]: 0 = 48'h0, 1 = m zero-extended to 48 bits, 2 = current p, 3 = dab.
REQ-016 SHALL select Z from opmode[3:2]: 0 = 48'h0, 1 = pcin, 2 = current p, 3 = c.
REQ-017 SHALL use cin = carryin & opmode[5] as the effective carry-in.
REQ-018 SHALL compute a 49-bit result: Z + X + cin when opmode[7] = 0, and Z - (X + cin) when opmode[7] = 1.
REQ-019 SHALL take result bits [47:0] as the P value and result bit [48] as the carry value.
REQ-020 SHALL, when OPMODEREG = 1, capture opmode on the rising edge when ce_opmode = 1 and hold it otherwise; all selects then take effect one cycle later.
REQ-021 SHALL, when PREG = 1, load p with the P value on the rising edge when ce_p = 1 and hold it otherwise.
REQ-022 SHALL, when CARRYOUTREG = 1, load carryout with the carry value on the rising edge when ce_p = 1.
REQ-023 SHALL give latency from operand input to p of PREG cycles, plus OPMODEREG cycles for a change of opmode.
REQ-024 SHALL, with X or Z = 2 and PREG = 1, accumulate once per enabled cycle.
REQ-025 SHALL, with X or Z = 2 and PREG = 0, use 48'h0 for the feedback source to avoid a combinational loop.
REQ-026 SHALL wrap p modulo 2^48 on overflow or underflow; carryout indicates the wrap.
REQ-027 SHALL give reset priority over ce_p and ce_opmode when both are asserted.

Reset
REQ-028 SHALL, on rst = 1 at a rising edge, clear the opmode register, p register and carryout register to 0.
REQ-029 SHALL resume operation on the first edge after rst deasserts, with accumulation restarting from 0.
REQ-030 SHALL NOT let rst affect combinational (unregistered) paths.

Structure
REQ-031 SHALL define the X/Z select encodings, OPMODE bit positions and the 48-bit width constant in a shared package, dsp48a1_pkg.
REQ-032 SHALL instantiate a single sub-module, sync_reg_mux (parameterized WIDTH, synchronous reset, ce, bypass select), for the opmode, P and carryout pipeline stages.

Verification
REQ-033 SHALL cover multiply-add: m=36'd6, c=48'd10, opmode=8'b0000_1101, all registers enabled -> p=16 two edges after opmode is applied, carryout=0.
REQ-034 SHALL cover accumulation: m=5, opmode=X=1 with Z=2, ce_p=1 for 4 cycles from reset -> p=5, 10, 15, 20.
REQ-035 SHALL cover subtract with carry-in: c=100, dab=30, carryin=1, opmode[7]=1, [5]=1, X=3, Z=3 -> p=69.
REQ-036 SHALL cover wrap: c=48'hFFFF_FFFF_FFFF, dab=1, add -> p=0, carryout=1.
REQ-037 SHALL cover reset mid-accumulation: assert rst together with ce_p=1 at p=15 -> p=0 next edge; next enabled cycle -> p=5.
REQ-038 SHALL cover ce hold: ce_p=0 with changing inputs -> p and carryout remain constant.
